// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 convolution frame controller.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_KSIZE    = 3;
    localparam int DEF_PIPE_LAT = 3;

    // Number of fully-populated windows in one frame.
    function automatic int valid_out_count(input int row_size, input int num_rows, input int ksize);
        return (row_size - ksize + 1) * (num_rows - ksize + 1);
    endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Window-valid / last-pixel tag pipeline that tracks the datapath latency,
// advancing only on enabled datapath beats.
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic vld_in,
    input  logic last_in,
    output logic vld_to_tail,
    output logic last_tail
);

    logic [PIPE_LAT-1:0] vld_sr;
    logic [PIPE_LAT-1:0] last_sr;
    logic [PIPE_LAT:0]   vld_chain;
    logic [PIPE_LAT:0]   last_chain;

    assign vld_chain   = {vld_sr, vld_in};
    assign last_chain  = {last_sr, last_in};
    // Bit that lands in the tail slot if this cycle is an enabled beat.
    assign vld_to_tail = vld_chain[PIPE_LAT-1];
    assign last_tail   = last_sr[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else if (clr) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else if (en) begin
            vld_sr  <= vld_chain[PIPE_LAT-1:0];
            last_sr <= last_chain[PIPE_LAT-1:0];
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: raster intake, end-of-frame
// drain and window-valid tagging. Optional counters under CONV_CTRL_PERF_EN.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540,
    parameter int NUM_ROWS  = 540,
    parameter int KSIZE     = DEF_KSIZE,
    parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] in_px,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] conv_px,
    output logic                 conv_en,
    output logic                 conv_clr,
    input  logic [WORD_SIZE-1:0] dp_px,
    output logic [WORD_SIZE-1:0] out_px,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_WIN    = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] ROW_WIN    = RW'(KSIZE - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW-1:0] flush_cnt;
    logic          at_eof;
    logic          tag_vld;
    logic          tag_last;
    logic          vld_to_tail;
    logic          last_tail;

    assign at_eof   = (row == ROW_LAST) && (col == COL_LAST);
    assign tag_vld  = (state == RUN) && (row >= ROW_WIN) && (col >= COL_WIN);
    assign tag_last = (state == RUN) && at_eof;
    assign out_px   = dp_px;
    assign out_last = out_valid & last_tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        conv_en    = 1'b0;
        conv_px    = '0;
        conv_clr   = 1'b0;
        busy       = (state != IDLE);
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                conv_clr  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                // Hold the datapath while an unaccepted result sits at its output.
                in_ready = !out_valid || out_ready;
                conv_en  = in_valid && in_ready;
                conv_px  = in_px;
                if (conv_en && at_eof) state_nxt = FLUSH;
            end
            FLUSH: begin
                conv_en = !out_valid || out_ready;
                if (conv_en && (flush_cnt == FLUSH_LAST)) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row       <= '0;
            col       <= '0;
            flush_cnt <= '0;
        end else if (state == CLEAR) begin
            row       <= '0;
            col       <= '0;
            flush_cnt <= '0;
        end else if ((state == RUN) && conv_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if ((state == FLUSH) && conv_en) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (conv_en && vld_to_tail) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    conv_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .clr         (conv_clr),
        .en          (conv_en),
        .vld_in      (tag_vld),
        .last_in     (tag_last),
        .vld_to_tail (vld_to_tail),
        .last_tail   (last_tail)
    );

`ifdef CONV_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                stall_cnt <= '0;
            end else if (((state == RUN) || (state == FLUSH)) && out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the 3x3 convolution datapath (sliding window, multiply, sum, clamp).
- Accepts a raster pixel stream with valid/ready, feeds the datapath one pixel per enabled beat, and tracks row/column position.
- Drains the datapath pipeline at end of frame and tags datapath results that correspond to fully-populated windows with out_valid/out_last.
- The datapath advances its window and pipeline registers only on beats where conv_en is high.

Parameters:
- WORD_SIZE, 8, pixel width in bits.
- ROW_SIZE, 540, pixels per row (columns).
- NUM_ROWS, 540, rows per frame.
- KSIZE, 3, kernel edge length; window valid from row/col index KSIZE-1.
- PIPE_LAT, 3, enabled beats from pixel entry to the result at the datapath output register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_px  in  WORD_SIZE  input pixel.
- in_valid  in  1  in_px valid.
- in_ready  out  1  controller accepts in_px this cycle.
- conv_px  out  WORD_SIZE  pixel to datapath inputPixel.
- conv_en  out  1  datapath advance enable.
- conv_clr  out  1  one-cycle datapath clear.
- dp_px  in  WORD_SIZE  datapath outputPixel.
- out_px  out  WORD_SIZE  result pixel (dp_px passthrough).
- out_valid  out  1  out_px holds a valid-window result.
- out_ready  in  1  downstream accepts out_px.
- out_last  out  1  qualifies the final valid result of the frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: state=IDLE, row=col=0, vld_sr=0; all outputs 0 (in_ready, conv_en, conv_clr, out_valid, out_last, busy, frame_done, conv_px).
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
  - IDLE -> CLEAR on start. conv_clr=1 during CLEAR; CLEAR lasts 1 cycle, then RUN.
  - RUN: beat when in_valid & in_ready. in_ready = (!out_valid | out_ready). conv_en = beat, conv_px = in_px.
  - RUN counters: col++ per beat; on col==ROW_SIZE-1, col<=0 and row++. On the beat with row==NUM_ROWS-1 & col==ROW_SIZE-1, go to FLUSH.
  - FLUSH: conv_en = (!out_valid | out_ready), conv_px=0, in_ready=0. Exactly PIPE_LAT enabled beats, counted by flush_cnt, then DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Window tag: on each RUN beat, tag = (row>=KSIZE-1) & (col>=KSIZE-1), using pre-increment counters. FLUSH beats shift in 0.
- vld_sr: PIPE_LAT-deep shift register, advanced only on conv_en.
- out_valid register: set on any conv_en beat whose shift moves 1 into vld_sr[PIPE_LAT-1]; cleared on out_valid & out_ready with no new set.
- out_valid stays high, and dp_px stays stable, until accepted, because conv_en is held low meanwhile.
- last_sr: parallel to vld_sr, tagging the beat row==NUM_ROWS-1 & col==ROW_SIZE-1. out_last = out_valid & last_sr[PIPE_LAT-1].
- Valid outputs per frame = (ROW_SIZE-KSIZE+1)*(NUM_ROWS-KSIZE+1). Row-wrap windows are never tagged.
- Boundary and corner cases:
  - start outside IDLE: ignored.
  - in_valid in IDLE/CLEAR/FLUSH/DONE: not accepted.
  - in_valid low in RUN: no beat, counters hold.
  - rst low at any time: immediate return to reset values; the partial frame is discarded; no frame_done.
  - Simultaneous out_ready acceptance and new tag: out_valid stays 1 (new result).

Optional Feature:
- CONV_CTRL_PERF_EN defined:
  - Adds outputs stall_cnt[31:0] and frame_cnt[15:0].
  - stall_cnt counts RUN/FLUSH cycles where out_valid & !out_ready; it clears on start.
  - frame_cnt increments on frame_done and wraps.
- CONV_CTRL_PERF_EN undefined: neither port nor its logic exists.

Decomposition:
- Package conv_pkg: state enum (IDLE, CLEAR, RUN, FLUSH, DONE), default KSIZE/PIPE_LAT constants, helper for valid-output count.
- One natural sub-module: conv_tag_pipe (PIPE_LAT-deep valid/last shift with enable), reusable if datapath latency changes.

Test Plan:
- ROW_SIZE=5, NUM_ROWS=4, in_valid and out_ready always 1, pixels 0..19:
  - exactly 6 out_valid pulses, out_last on the 6th, frame_done 3 cycles after FLUSH entry plus 1, and busy low afterwards.
- Same config, out_ready low for 4 cycles on the 2nd result:
  - out_valid held, out_px stable, in_ready=0, no counter advance; 6 results total in order.
- Same config, in_valid toggled 1-0-1 randomly:
  - result count still 6; window tags match the raster position, with none at col 0/1 or row 0/1.
- rst driven low mid-RUN at row 2 col 3:
  - all outputs 0 immediately; next start produces a clean 6-result frame.
- start pulsed during RUN and FLUSH:
  - ignored; exactly one frame_done.
- With CONV_CTRL_PERF_EN defined:
  - two frames with 4 stall cycles each give frame_cnt=2; stall_cnt=4 after the 2nd frame.
